// File: rtl/ceas_time_counter.sv
// Time-of-day core: synchronises the 100 Hz divider output, turns each rising edge into a tick,
// and keeps hh:mm:ss.cc in packed BCD with registered wrap pulses.
module ceas_time_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_MOD    = 24
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_100hz,
  input  logic       run,
  input  logic       clear,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] cc,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  localparam logic [7:0] HH_LAST = (HOUR_MOD == 12) ? 8'h11 : 8'h23;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic                   hist_q, arm_q;
  logic                   sync_out, tick;

  logic [7:0] hh_q, mm_q, ss_q, cc_q;
  logic [7:0] hh_d, mm_d, ss_d, cc_d;
  logic       sec_q, min_q, day_q, err_q;
  logic       sec_d, min_d, day_d, err_d;
  logic       set_ok, wrap_c, wrap_s, wrap_m, wrap_h;

  // Input synchroniser and edge detect. fill_q marks when sync_out holds a genuine
  // post-reset sample; ticks are armed only after a low level has been seen, so a
  // clk_100hz that is already high when reset releases does not count as an edge.
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = sync_out & ~hist_q & arm_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      hist_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_100hz};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= sync_out;
      if (fill_q[SYNC_STAGES-1] && !sync_out) arm_q <= 1'b1;
    end
  end

  // Next-state time digits: clear beats set_en beats a running tick.
  always_comb begin
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    cc_d   = cc_q;
    sec_d  = 1'b0;
    min_d  = 1'b0;
    day_d  = 1'b0;
    err_d  = 1'b0;
    wrap_c = (cc_q == 8'h99);
    wrap_s = wrap_c && (ss_q == 8'h59);
    wrap_m = wrap_s && (mm_q == 8'h59);
    wrap_h = wrap_m && (hh_q == HH_LAST);
    set_ok = bcd_ok(set_hh) && bcd_ok(set_mm) && (set_hh <= HH_LAST) && (set_mm <= 8'h59);

    if (clear) begin
      hh_d = 8'h00;
      mm_d = 8'h00;
      ss_d = 8'h00;
      cc_d = 8'h00;
    end else if (set_en) begin
      if (set_ok) begin
        hh_d = set_hh;
        mm_d = set_mm;
        ss_d = 8'h00;
        cc_d = 8'h00;
      end else begin
        err_d = 1'b1;
      end
    end else if (tick && run) begin
      cc_d  = wrap_c ? 8'h00 : bcd_inc(cc_q);
      sec_d = wrap_c;
      if (wrap_c) ss_d = wrap_s ? 8'h00 : bcd_inc(ss_q);
      min_d = wrap_s;
      if (wrap_s) mm_d = wrap_m ? 8'h00 : bcd_inc(mm_q);
      if (wrap_m) hh_d = wrap_h ? 8'h00 : bcd_inc(hh_q);
      day_d = wrap_h;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hh_q  <= 8'h00;
      mm_q  <= 8'h00;
      ss_q  <= 8'h00;
      cc_q  <= 8'h00;
      sec_q <= 1'b0;
      min_q <= 1'b0;
      day_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
      cc_q  <= cc_d;
      sec_q <= sec_d;
      min_q <= min_d;
      day_q <= day_d;
      err_q <= err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign cc        = cc_q;
  assign sec_pulse = sec_q;
  assign min_pulse = min_q;
  assign day_pulse = day_q;
  assign set_err   = err_q;

endmodule
